decode_stage_rf: RTL and testbench
==================================

// Module: decode_stage_rf
// PURPOSE
//  Parametrised RV32I decode stage: register file, immediate generator and scoreboard in one block.
//  Sits between the fetch buffer and execute, with a valid/ready handshake on both sides.
//  Writeback-to-read bypass and RAW hazard stalling let execute/writeback be multi-cycle.
//  One registered output stage: accepted instruction appears on out_* one cycle later.
// PARAMETERS
//  XLEN      32            datapath/register width; immediates sign-extended to XLEN
//  SP_IDX    2             register index preset at reset (stack pointer)
//  SP_RESET  32'h0001_0000 reset value of x[SP_IDX], truncated/zero-extended to XLEN
//  BYPASS    1             1: same-cycle writeback forwarded to operand read; 0: array only
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst          in   1     asynchronous, active-high reset
//  in_valid     in   1     fetch offers in_inst
//  in_ready     out  1     decode accepts in_inst this cycle
//  in_inst      in   32    instruction word
//  flush        in   1     squash instruction held in output stage
//  wb_en        in   1     register write strobe
//  wb_rd        in   5     register written
//  wb_data      in   XLEN  write data
//  out_valid    out  1     out_* hold a decoded instruction
//  out_ready    in   1     execute accepts out_*
//  out_rs1_data out  XLEN  operand 1 (0 if rs1 unused)
//  out_rs2_data out  XLEN  operand 2 (0 if rs2 unused)
//  out_rd       out  5     destination index
//  out_wr       out  1     instruction writes out_rd (0 when out_rd==0)
//  out_imm      out  XLEN  sign-extended immediate
//  out_illegal  out  1     unrecognised opcode
// BEHAVIOUR
//  Reset (async, any time): all x[i]=0 except x[SP_IDX]=SP_RESET. Outputs and scoreboard cleared, so out_valid=0.
//    Reset mid-stall discards the held instruction.
//  x0 reads 0 always; writes to x0 ignored; x0 never pending.
//  Opcode classes:
//    R 0110011; I 0010011/0000011/1100111; S 0100011; B 1100011; U 0110111/0010111; J 1101111.
//  rs1 used: R,I,S,B. rs2 used: R,S,B. Writes rd: R,I,U,J.
//  Immediate: I {sx,inst[31:20]}; S {sx,inst[31:25],inst[11:7]};
//    B {sx,inst[31],inst[7],inst[30:25],inst[11:8],0}; U {sx,inst[31:12],12'b0};
//    J {sx,inst[31],inst[19:12],inst[20],inst[30:21],0}; R/illegal 0.
//  Illegal opcode: out_illegal=1, no operands used, out_wr=0, imm=0.
//  Scoreboard pend[31:1]:
//    set on accept when wr && rd!=0; cleared on wb_en && wb_rd!=0.
//    Set and clear of the same index in one cycle: set wins.
//  Hazard: a used rs is pending, unless (BYPASS && wb_en && wb_rd==rs) that cycle.
//  in_ready = !flush && !hazard && (!out_valid || out_ready); accept = in_valid && in_ready.
//  Operand read: bypassed wb_data if BYPASS && wb_en && wb_rd==rs && rs!=0, else array.
//  Register write happens at the same edge.
//  On accept, out_* load at next edge, so latency is 1 cycle.
//    Else if out_ready, out_valid<=0; else out_* hold stable.
//  flush: out_valid<=0. If out_valid && out_wr, clear pend[out_rd], unless set by an accept
//    that same cycle (impossible since in_ready=0).
//  wb to an index not pending: array written, no error.
// STRUCTURE
//  Package rv_decode_pkg: opcode localparams, imm-format enum, instruction field slice helpers.
//  Sub-module imm_gen (combinational: inst -> imm, fmt, rs1_used, rs2_used, wr, illegal).
//  Top holds the register array, scoreboard and output register.
// TESTING
//  Reset: assert rst mid-run -> x2==32'h0001_0000, all other regs 0, out_valid=0 immediately.
//  addi x5,x0,-1 (32'hFFF00293) -> next cycle out_imm=32'hFFFF_FFFF, out_rd=5, out_wr=1, pend[5]=1.
//  RAW stall: addi x5 accepted, then add x6,x5,x5 offered -> in_ready=0.
//    After wb(x5=7), BYPASS=1 accepts in the wb cycle with rs1/rs2_data=7; BYPASS=0 accepts one cycle later.
//  Backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 -> next accept.
//  Flush: sw x5,8(x2) then lui x7 in output stage with flush=1 -> out_valid=0 next cycle, pend[7]=0.
//    sw x5,8(x2) -> out_imm=8, out_wr=0.
//  Write x0 via wb (wb_rd=0, data=5) -> subsequent rs1=x0 reads 0. opcode 7'h7F -> out_illegal=1, out_imm=0.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions.
// Holds the base opcode values, the immediate-format enum and small helpers that slice
// the fixed instruction fields. There are no ports; the decode modules import it.
package rv_decode_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef enum logic [2:0] {
    FmtR,
    FmtI,
    FmtS,
    FmtB,
    FmtU,
    FmtJ,
    FmtIll
  } imm_fmt_e;

  function automatic logic [6:0] get_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational instruction classifier and immediate generator.
// Ports:
//   inst     - 32-bit instruction word
//   imm      - immediate, sign-extended to XLEN (0 for R-type and illegal opcodes)
//   fmt      - immediate format / instruction class
//   rs1_used - instruction reads rs1
//   rs2_used - instruction reads rs2
//   wr       - instruction class writes rd (rd==0 is not filtered here)
//   illegal  - opcode is not one of the supported RV32I classes
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            wr,
  output logic            illegal
);

  // Built at 32 bits and then resized; the signed type makes the resize sign-extend.
  logic signed [31:0] imm32;

  always_comb begin
    fmt = FmtIll;
    case (get_opcode(inst))
      OpcOp:                      fmt = FmtR;
      OpcOpImm, OpcLoad, OpcJalr: fmt = FmtI;
      OpcStore:                   fmt = FmtS;
      OpcBranch:                  fmt = FmtB;
      OpcLui, OpcAuipc:           fmt = FmtU;
      OpcJal:                     fmt = FmtJ;
      default:                    fmt = FmtIll;
    endcase
  end

  always_comb begin
    imm32    = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    wr       = 1'b0;
    illegal  = 1'b0;
    case (fmt)
      FmtR: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        wr       = 1'b1;
      end
      FmtI: begin
        imm32    = {{20{inst[31]}}, inst[31:20]};
        rs1_used = 1'b1;
        wr       = 1'b1;
      end
      FmtS: begin
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      FmtB: begin
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      FmtU: begin
        imm32 = {inst[31:12], 12'b0};
        wr    = 1'b1;
      end
      FmtJ: begin
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        wr    = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage_rf.sv
// RV32I decode stage: register file, immediate generation and RAW scoreboard.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   in_valid/in_ready   - fetch handshake, in_inst is the offered instruction word
//   flush               - squash the instruction held in the output stage
//   wb_en/wb_rd/wb_data - register writeback port
//   out_valid/out_ready - execute handshake for the registered out_* bundle
//   out_rs1_data/rs2    - operands (0 when the source is unused)
//   out_rd/out_wr       - destination index and write flag (out_wr=0 when rd is x0)
//   out_imm             - sign-extended immediate
//   out_illegal         - unrecognised opcode
module decode_stage_rf
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SP_IDX   = 2,
  parameter logic [31:0] SP_RESET = 32'h0001_0000,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_wr,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [XLEN-1:0] SpResetVal = XLEN'(SP_RESET);

  logic [XLEN-1:0] regs_q [32];
  logic [31:0]     pend_q, pend_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_rs1_q, out_rs1_d;
  logic [XLEN-1:0] out_rs2_q, out_rs2_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wr_q, out_wr_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic            out_ill_q, out_ill_d;

  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_rs1_used, dec_rs2_used, dec_wr, dec_illegal;
  logic            dec_has_rd;
  logic            fwd_rs1, fwd_rs2, hazard, accept, wb_write;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign dec_rs1 = get_rs1(in_inst);
  assign dec_rs2 = get_rs2(in_inst);
  assign dec_rd  = get_rd(in_inst);

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .rs1_used(dec_rs1_used),
    .rs2_used(dec_rs2_used),
    .wr      (dec_wr),
    .illegal (dec_illegal)
  );

  // S, B and illegal encodings carry no destination, so report index 0 for them.
  assign dec_has_rd = dec_fmt inside {FmtR, FmtI, FmtU, FmtJ};

  assign wb_write = wb_en && (wb_rd != 5'd0);

  // A writeback landing this cycle both resolves the hazard and supplies the operand.
  assign fwd_rs1 = BYPASS && wb_en && (wb_rd == dec_rs1) && (dec_rs1 != 5'd0);
  assign fwd_rs2 = BYPASS && wb_en && (wb_rd == dec_rs2) && (dec_rs2 != 5'd0);

  assign hazard = (dec_rs1_used && pend_q[dec_rs1] && !fwd_rs1) ||
                  (dec_rs2_used && pend_q[dec_rs2] && !fwd_rs2);

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // regs_q[0] is reset to 0 and never written, so x0 reads need no special case.
  assign rs1_val = fwd_rs1 ? wb_data : regs_q[dec_rs1];
  assign rs2_val = fwd_rs2 ? wb_data : regs_q[dec_rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= ((i == SP_IDX) && (i != 0)) ? SpResetVal : '0;
      end
    end else if (wb_write) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Clears come first so that a same-cycle set of the same index wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_write) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (flush && out_valid_q && out_wr_q) begin
      pend_d[out_rd_q] = 1'b0;
    end
    if (accept && dec_wr && (dec_rd != 5'd0)) begin
      pend_d[dec_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    out_wr_d    = out_wr_q;
    out_imm_d   = out_imm_q;
    out_ill_d   = out_ill_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_rs1_d   = dec_rs1_used ? rs1_val : '0;
      out_rs2_d   = dec_rs2_used ? rs2_val : '0;
      out_rd_d    = dec_has_rd ? dec_rd : 5'd0;
      out_wr_d    = dec_wr && (dec_rd != 5'd0);
      out_imm_d   = dec_imm;
      out_ill_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
      out_imm_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
      out_imm_q   <= out_imm_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_wr       = out_wr_q;
  assign out_imm      = out_imm_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_decode_stage_rf.sv
// Self-checking bench for decode_stage_rf: directed scenarios plus a randomized run checked
// against a behavioural model of the register file, scoreboard and output stage.
module tb_decode_stage_rf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = 32'h0, wb_data = 32'h0;
  logic [4:0]  wb_rd = 5'd0;
  logic        in_ready, out_valid, out_wr, out_illegal;
  logic [31:0] out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;

  // Second instance without the writeback bypass, driven only by its own test.
  logic        nb_in_valid = 1'b0, nb_wb_en = 1'b0, nb_flush = 1'b0, nb_out_ready = 1'b1;
  logic [31:0] nb_in_inst = 32'h0, nb_wb_data = 32'h0;
  logic [4:0]  nb_wb_rd = 5'd0;
  logic        nb_in_ready, nb_out_valid, nb_out_wr, nb_out_illegal;
  logic [31:0] nb_rs1, nb_rs2, nb_imm;
  logic [4:0]  nb_out_rd;

  decode_stage_rf #(.XLEN(32), .SP_IDX(2), .SP_RESET(32'h0001_0000), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_wr(out_wr), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  decode_stage_rf #(.XLEN(32), .SP_IDX(2), .SP_RESET(32'h0001_0000), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .in_valid(nb_in_valid), .in_ready(nb_in_ready),
    .in_inst(nb_in_inst), .flush(nb_flush), .wb_en(nb_wb_en), .wb_rd(nb_wb_rd),
    .wb_data(nb_wb_data), .out_valid(nb_out_valid), .out_ready(nb_out_ready),
    .out_rs1_data(nb_rs1), .out_rs2_data(nb_rs2), .out_rd(nb_out_rd), .out_wr(nb_out_wr),
    .out_imm(nb_imm), .out_illegal(nb_out_illegal)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the bypassing instance.
  logic [31:0] m_x [32];
  bit          m_pend [32];
  bit          m_ov, m_wr, m_ill;
  logic [31:0] m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                           7'h7F, 7'h00};

  // 0 illegal, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
  function automatic int cls_of(logic [31:0] w);
    case (w[6:0])
      7'h33:               return 1;
      7'h13, 7'h03, 7'h67: return 2;
      7'h23:               return 3;
      7'h63:               return 4;
      7'h37, 7'h17:        return 5;
      7'h6F:               return 6;
      default:             return 0;
    endcase
  endfunction

  function automatic bit uses_rs1(int c); return c >= 1 && c <= 4; endfunction
  function automatic bit uses_rs2(int c); return c == 1 || c == 3 || c == 4; endfunction
  function automatic bit writes_rd(int c); return c == 1 || c == 2 || c == 5 || c == 6; endfunction

  function automatic logic [31:0] imm_of(logic [31:0] w);
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (cls_of(w))
      2: return (sx << 12) | (w >> 20);
      3: return (sx << 12) | (((w >> 25) & 32'h7f) << 5) | ((w >> 7) & 32'h1f);
      4: return (sx << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3f) << 5)
                | (((w >> 8) & 32'hf) << 1);
      5: return w & 32'hFFFF_F000;
      6: return (sx << 20) | (((w >> 12) & 32'hff) << 12) | (((w >> 20) & 32'h1) << 11)
                | (((w >> 21) & 32'h3ff) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] r_type(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic bit m_ready();
    int c, r1, r2;
    bit h;
    c  = cls_of(in_inst);
    r1 = int'(in_inst[19:15]);
    r2 = int'(in_inst[24:20]);
    h  = (uses_rs1(c) && m_pend[r1] && !(wb_en && wb_rd == r1)) ||
         (uses_rs2(c) && m_pend[r2] && !(wb_en && wb_rd == r2));
    return !flush && !h && (!m_ov || out_ready);
  endfunction

  function automatic logic [31:0] m_opnd(int r);
    if (wb_en && wb_rd == r && r != 0) return wb_data;
    return m_x[r];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_x[i]    = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_x[2] = 32'h0001_0000;
    m_ov   = 1'b0;
    m_wr   = 1'b0;
    m_ill  = 1'b0;
    m_rs1  = 32'h0;
    m_rs2  = 32'h0;
    m_imm  = 32'h0;
    m_rd   = 5'd0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    bit acc;
    int c;
    @(negedge clk);
    c   = cls_of(in_inst);
    acc = in_valid && m_ready();
    if (wb_en && wb_rd != 0) m_pend[wb_rd] = 1'b0;
    if (flush && m_ov && m_wr) m_pend[m_rd] = 1'b0;
    if (flush) begin
      m_ov = 1'b0;
    end else if (acc) begin
      m_ov  = 1'b1;
      m_wr  = writes_rd(c) && in_inst[11:7] != 0;
      m_rd  = in_inst[11:7];
      m_imm = imm_of(in_inst);
      m_ill = (c == 0);
      m_rs1 = uses_rs1(c) ? m_opnd(int'(in_inst[19:15])) : 32'h0;
      m_rs2 = uses_rs2(c) ? m_opnd(int'(in_inst[24:20])) : 32'h0;
      if (m_wr) m_pend[m_rd] = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (wb_en && wb_rd != 0) m_x[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic rand_inputs();
    int cand [$];
    in_valid  = ($urandom_range(0, 3) != 0);
    in_inst   = rand_inst();
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 15) == 0);
    wb_en     = ($urandom_range(0, 2) == 0);
    for (int r = 1; r < 8; r++) if (m_pend[r]) cand.push_back(r);
    if (cand.size() > 0 && $urandom_range(0, 3) != 0)
      wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
    else
      wb_rd = 5'($urandom_range(0, 7));
    wb_data = $urandom;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    out_ready = 1'b1; nb_in_valid = 1'b0; nb_wb_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    in_valid = 1'b1;
    in_inst  = {20'h11111, 5'd1, 7'h37};
    tick();
    out_ready = 1'b0;
    in_inst   = {20'h22222, 5'd3, 7'h37};
    tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL held_before_reset got=%b exp=1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || nb_out_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset_valid got=%b/%b exp=0/0", out_valid, nb_out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_inst  = r_type(5'd0, 5'(i), 5'(31 - i));
      tick();
      e1 = (i == 2) ? 32'h0001_0000 : 32'h0;
      e2 = (i == 29) ? 32'h0001_0000 : 32'h0;
      total++;
      if (out_valid !== 1'b1 || out_rs1_data !== e1 || out_rs2_data !== e2) begin
        bad++;
        $display("FAIL reset_reg_%0d got=%b %h %h exp=1 %h %h", i, out_valid, out_rs1_data,
                 out_rs2_data, e1, e2);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_addi_raw();
    logic [31:0] add6;
    add6 = r_type(5'd6, 5'd5, 5'd5);
    do_reset();
    in_valid = 1'b1;
    in_inst  = 32'hFFF0_0293;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
    tick();
    total++;
    if ({out_valid, out_imm, out_rd, out_wr} !== {1'b1, 32'hFFFF_FFFF, 5'd5, 1'b1}) begin
      bad++;
      $display("FAIL addi_out got=%b %h %0d %b exp=1 ffffffff 5 1", out_valid, out_imm,
               out_rd, out_wr);
    end
    in_inst = add6;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b exp=0", in_ready); end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL raw_stall_hold got=%b/%b exp=0/0", in_ready, out_valid);
    end
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bypass_accept got=%b exp=1", in_ready); end
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_rs1_data, out_rs2_data, out_rd} !== {1'b1, 32'd7, 32'd7, 5'd6}) begin
      bad++;
      $display("FAIL bypass_data got=%b %h %h %0d exp=1 7 7 6", out_valid, out_rs1_data,
               out_rs2_data, out_rd);
    end
  endtask

  task automatic test_nobypass();
    do_reset();
    nb_in_valid = 1'b1;
    nb_in_inst  = 32'hFFF0_0293;
    tick();
    nb_in_inst = r_type(5'd6, 5'd5, 5'd5);
    #1;
    total++;
    if (nb_in_ready !== 1'b0) begin bad++; $display("FAIL nb_stall got=%b exp=0", nb_in_ready); end
    tick();
    nb_wb_en = 1'b1; nb_wb_rd = 5'd5; nb_wb_data = 32'd7;
    #1;
    total++;
    if (nb_in_ready !== 1'b0) begin
      bad++; $display("FAIL nb_wb_cycle got=%b exp=0", nb_in_ready);
    end
    tick();
    nb_wb_en = 1'b0;
    #1;
    total++;
    if (nb_in_ready !== 1'b1) begin
      bad++; $display("FAIL nb_next_cycle got=%b exp=1", nb_in_ready);
    end
    tick();
    nb_in_valid = 1'b0;
    total++;
    if ({nb_out_valid, nb_rs1, nb_rs2} !== {1'b1, 32'd7, 32'd7}) begin
      bad++; $display("FAIL nb_data got=%b %h %h exp=1 7 7", nb_out_valid, nb_rs1, nb_rs2);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    in_inst  = {12'd100, 5'd0, 3'b000, 5'd8, 7'h13};
    tick();
    out_ready = 1'b0;
    in_inst   = {20'hABCDE, 5'd9, 7'h37};
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready_%0d got=%b exp=0", k, in_ready);
      end
      total++;
      if ({out_valid, out_rd, out_imm, out_wr} !== {1'b1, 5'd8, 32'd100, 1'b1}) begin
        bad++;
        $display("FAIL bp_stable_%0d got=%b %0d %h %b exp=1 8 64 1", k, out_valid, out_rd,
                 out_imm, out_wr);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd9, 32'hABCD_E000}) begin
      bad++; $display("FAIL bp_next got=%b %0d %h exp=1 9 abcde000", out_valid, out_rd, out_imm);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    in_inst  = {7'b0, 5'd5, 5'd2, 3'b010, 5'd8, 7'h23};
    tick();
    total++;
    if ({out_valid, out_imm, out_wr, out_rs1_data} !== {1'b1, 32'd8, 1'b0, 32'h0001_0000}) begin
      bad++;
      $display("FAIL sw_out got=%b %h %b %h exp=1 8 0 10000", out_valid, out_imm, out_wr,
               out_rs1_data);
    end
    in_inst = {20'h12345, 5'd7, 7'h37};
    tick();
    total++;
    if ({out_valid, out_rd, out_wr} !== {1'b1, 5'd7, 1'b1}) begin
      bad++; $display("FAIL lui_out got=%b %0d %b exp=1 7 1", out_valid, out_rd, out_wr);
    end
    flush = 1'b1; out_ready = 1'b0;
    in_inst = r_type(5'd0, 5'd7, 5'd0);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clears got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_pend_cleared got=%b exp=1", in_ready);
    end
    tick();
    out_ready = 1'b1; in_valid = 1'b0;
    total++;
    if ({out_valid, out_rs1_data} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL flush_read_x7 got=%b %h exp=1 0", out_valid, out_rs1_data);
    end
  endtask

  task automatic test_x0_illegal();
    do_reset();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd5;
    in_valid = 1'b1;
    in_inst  = r_type(5'd0, 5'd0, 5'd0);
    tick();
    wb_en = 1'b0;
    total++;
    if (out_rs1_data !== 32'h0) begin
      bad++; $display("FAIL x0_bypass got=%h exp=0", out_rs1_data);
    end
    tick();
    total++;
    if (out_rs1_data !== 32'h0) begin
      bad++; $display("FAIL x0_after_wb got=%h exp=0", out_rs1_data);
    end
    in_inst = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_illegal, out_imm, out_wr, out_rs1_data, out_rs2_data} !==
        {1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL illegal got=%b %b %h %b %h %h exp=1 1 0 0 0 0", out_valid, out_illegal,
               out_imm, out_wr, out_rs1_data, out_rs2_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      #1;
      total++;
      if (in_ready !== m_ready()) begin
        bad++; $display("FAIL rnd_ready_%0d got=%b exp=%b", n, in_ready, m_ready());
      end
      total++;
      if (out_valid !== m_ov) begin
        bad++; $display("FAIL rnd_valid_%0d got=%b exp=%b", n, out_valid, m_ov);
      end
      if (m_ov) begin
        total++;
        if ({out_rs1_data, out_rs2_data, out_imm, out_wr, out_illegal} !==
            {m_rs1, m_rs2, m_imm, m_wr, m_ill}) begin
          bad++;
          $display("FAIL rnd_out_%0d got=%h %h %h %b %b exp=%h %h %h %b %b", n, out_rs1_data,
                   out_rs2_data, out_imm, out_wr, out_illegal, m_rs1, m_rs2, m_imm, m_wr, m_ill);
        end
        if (m_wr) begin
          total++;
          if (out_rd !== m_rd) begin
            bad++; $display("FAIL rnd_rd_%0d got=%0d exp=%0d", n, out_rd, m_rd);
          end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_addi_raw();
    test_nobypass();
    test_backpressure();
    test_flush();
    test_x0_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
